shift_rotate_unit: RTL and testbench

- Parametrised, pipelined shift/rotate functional unit for the ALU datapath. It supersedes the fixed 32-bit combinational rotate-left gate.
- Supports rotate left/right, logical shift left/right and arithmetic shift right on a WIDTH-bit operand.
- Two-stage log-shifter with valid/ready handshakes on input and output, so it can sit between the operand registers and the Z/result register under stall control.

---
 rtl/shift_rotate_unit.sv | 129 ++++++++++++
 tb/tb_shift_rotate_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_unit.sv
// Two-stage pipelined rotate/shift unit (ROL, ROR, SHL, SHR, SHRA) on a WIDTH-bit operand.
// Latency: 2 cycles from input transfer to out_valid; throughput 1 result per cycle.
// Backpressure: valid/ready on both sides; in_ready is combinational from out_ready only.
module shift_rotate_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int FINE_W  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_err
);

  localparam logic [2:0] OP_ROL  = 3'd0;
  localparam logic [2:0] OP_ROR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_SHRA = 3'd4;

  // Log-shifter: each set bit i of n applies a 2**i step. Illegal ops pass
  // the value through untouched, which gives the "unshifted on error" result.
  // SHRA fill comes from the supplied sign, not from the partially shifted
  // value, so the fine stage fills correctly after a coarse shift.
  function automatic logic [WIDTH-1:0] log_shift(
    input logic [WIDTH-1:0]   v,
    input logic [2:0]         op,
    input logic [SHAMT_W-1:0] n,
    input logic               sign
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill;
    r = v;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (n[i]) begin
        fill = sign ? ~({WIDTH{1'b1}} >> (1 << i)) : '0;
        case (op)
          OP_ROL:  r = (r << (1 << i)) | (r >> (WIDTH - (1 << i)));
          OP_ROR:  r = (r >> (1 << i)) | (r << (WIDTH - (1 << i)));
          OP_SHL:  r = r << (1 << i);
          OP_SHR:  r = r >> (1 << i);
          OP_SHRA: r = (r >> (1 << i)) | fill;
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

  // Stage 1 registers
  logic               s1_valid;
  logic [2:0]         s1_op;
  logic [FINE_W-1:0]  s1_fine;
  logic               s1_sign;
  logic               s1_err;
  logic [WIDTH-1:0]   s1_data;

  // Stage 2 state (the output registers)
  logic               s2_valid;

  // Handshake / advance terms
  logic s1_adv;
  logic s2_adv;
  logic in_fire;

  // Coarse shift amount: upper bits only, low FINE_W bits forced to zero.
  logic [SHAMT_W-1:0] coarse_n;
  logic [SHAMT_W-1:0] fine_n;
  logic [WIDTH-1:0]   coarse_val;
  logic [WIDTH-1:0]   fine_val;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign in_fire   = in_valid && s1_adv;
  assign out_valid = s2_valid;

  assign coarse_n   = {in_shamt[SHAMT_W-1:FINE_W], {FINE_W{1'b0}}};
  assign fine_n     = {{(SHAMT_W-FINE_W){1'b0}}, s1_fine};
  assign coarse_val = log_shift(in_a, in_op, coarse_n, in_a[WIDTH-1]);
  assign fine_val   = log_shift(s1_data, s1_op, fine_n, s1_sign);

  // Stage 1: capture op, fine bits, sign and coarse-shifted operand on input transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_fine  <= '0;
      s1_sign  <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_op   <= in_op;
        s1_fine <= in_shamt[FINE_W-1:0];
        s1_sign <= in_a[WIDTH-1];
        s1_err  <= (in_op > OP_SHRA);
        s1_data <= coarse_val;
      end
    end
  end

  // Stage 2: apply fine shift and register result/flags; hold while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= fine_val;
        out_zero   <= (fine_val == '0);
        out_err    <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit: directed cases, backpressure,
// random streams against a reference model, and mid-flight reset.
module tb_shift_rotate_unit;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_err;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  shift_rotate_unit #(.WIDTH(32), .FINE_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rotate via a doubled operand, shifts via native operators.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input int n);
    logic [63:0] d;
    logic [31:0] r;
    d = {a, a};
    case (op)
      3'd0: begin d = d << n; r = d[63:32]; end
      3'd1: begin d = d >> n; r = d[31:0]; end
      3'd2: r = a << n;
      3'd3: r = a >> n;
      3'd4: r = 32'($signed(a) >>> n);
      default: r = a;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle: values seen here are what the next edge transfers.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res;
  logic        prev_zero, prev_err;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_result", out_result, prev_res);
        check("hold_flags", {30'd0, out_zero, out_err}, {30'd0, prev_zero, prev_err});
      end
      prev_hold = out_valid && !out_ready;
      prev_res  = out_result;
      prev_zero = out_zero;
      prev_err  = out_err;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_result", out_result, e.res);
          check("sb_flags", {30'd0, out_zero, out_err}, {30'd0, e.zero, e.err});
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.res  = ref_model(in_op, in_a, int'(in_shamt));
        e.zero = (e.res == 32'd0);
        e.err  = (in_op > 3'd4);
        sb_q.push_back(e);
      end
    end
  end

  // One transaction with out_ready high; called at posedge+1 with an idle pipe.
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [4:0] n, input logic [31:0] exp,
                        input logic ez, input logic ee);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_shamt  = n;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid_c1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_c2"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, out_result, exp);
    check({tag, "_zero"}, 32'(out_zero), 32'(ez));
    check({tag, "_err"}, 32'(out_err), 32'(ee));
    @(posedge clk); #1;
  endtask

  // Random stream of n items; rnd_ready toggles out_ready randomly.
  task automatic stream(input string tag, input int n, input bit rnd_ready);
    logic [2:0]  ops[];
    logic [31:0] as[];
    logic [4:0]  ns[];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    ops = new[n]; as = new[n]; ns = new[n];
    for (int i = 0; i < n; i++) begin
      ops[i] = 3'($urandom_range(0, 7));
      as[i]  = $urandom;
      ns[i]  = 5'($urandom_range(0, 31));
    end
    while (got < n && cyc < 2000) begin
      in_valid = (sent < n);
      if (sent < n) begin
        in_op = ops[sent]; in_a = as[sent]; in_shamt = ns[sent];
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(n));
    if (!rnd_ready) check({tag, "_cycles"}, 32'(cyc), 32'(n + 2));
  endtask

  initial begin
    logic [31:0] got_q[$];
    int sent;
    int cyc;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 32'd0;
    in_shamt  = 5'd0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_flags", {30'd0, out_zero, out_err}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    single("rol1",  3'd0, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1'b0);
    single("ror4",  3'd1, 32'h0000_0001, 5'd4,  32'h1000_0000, 1'b0, 1'b0);
    single("shr31", 3'd3, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0);
    single("sra31", 3'd4, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    single("shl31", 3'd2, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    for (int op = 0; op < 5; op++)
      single("n0", 3'(op), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    single("shl_zero", 3'd2, 32'hF000_0000, 5'd4, 32'h0000_0000, 1'b1, 1'b0);
    single("illegal",  3'd6, 32'h1234_5678, 5'd9, 32'h1234_5678, 1'b0, 1'b1);
    single("rol_ror_eq", 3'd1, 32'hA5C3_0F71, 5'd27, ref_model(3'd0, 32'hA5C3_0F71, 5), 1'b0, 1'b0);

    // Backpressure: four ROLs of 1, stall 5 cycles after first result
    out_ready = 1'b1;
    in_valid  = 1'b1; in_op = 3'd0; in_a = 32'h1; in_shamt = 5'd1;
    @(posedge clk); #1;
    in_shamt = 5'd2;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_shamt  = 5'd3;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_result", out_result, 32'h2);
      check("bp_stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    sent = 2;
    cyc  = 0;
    #1;
    while (got_q.size() < 4 && cyc < 20) begin
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got_q.push_back(out_result);
      @(posedge clk); #1;
      in_valid = (sent < 4);
      in_shamt = 5'(sent + 1);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_count", 32'(got_q.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size()) check("bp_order", got_q[k], 32'h2 << k);
    @(posedge clk); #1;

    // Random streams
    stream("stream_full", 64, 1'b0);
    stream("stream_rnd", 64, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1; in_op = 3'd2; in_a = 32'h0000_00FF; in_shamt = 5'd3;
    @(posedge clk); #1;
    in_shamt = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_full_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", out_result, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("mid_no_stale", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    single("post_rst_ror", 3'd1, 32'h1, 5'd1, 32'h8000_0000, 1'b0, 1'b0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
